captura_entrada: RTL
====================

# captura_entrada

Input-capture stage that sits directly upstream of the CPU's IN path. It synchronizes and debounces the board push-button and the 4-bit switch bank, and serves one IN request at a time with a level request/valid handshake. Each served request delivers a zero-extended 32-bit datum plus the single-cycle `botaoIN` pulse that the CPU's halt/IO logic consumes.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable clock cycles required to accept a button level change (10 ms at 50 MHz); legal range ≥ 2.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth for `botaoPlaca` and `entradaDeDados`; legal range ≥ 2.

Ports:
- `clock`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  **asynchronous, active-low** reset.
- `botaoPlaca`  input  1  raw board key, asynchronous, active-low (0 = pressed).
- `entradaDeDados`  input  4  raw switches, asynchronous.
- `pedidoIN`  input  1  level request from the control unit: high while an IN instruction waits for data.
- `dadoCapturado`  output  32  captured switch value, zero-extended (`{28'b0, sw}`).
- `dadoValido`  output  1  high while `dadoCapturado` holds data for the current request.
- `botaoIN`  output  1  one-cycle pulse marking completion of a request.
- `ledEspera`  output  1  high while waiting for the operator (drives `ledin`).

## Operation
- Synchronizer: `SYNC_STAGES` FFs per bit on the key and the switches. Switches are synchronized per bit only; the value is stable by construction when the key is pressed.
- Debounce:
  - A counter of width clog2(`DEBOUNCE_CYCLES`) clears whenever the synchronized key equals the debounced state.
  - Otherwise it increments. When it reaches `DEBOUNCE_CYCLES-1`, the debounced state toggles and the counter clears.
  - One-cycle `pressEdge`/`releaseEdge` strobes are derived from the debounced state.
- FSM states:
  - OCIOSO: waiting for a request. Goes to ESPERA_PRESS when `pedidoIN` = 1.
  - ESPERA_PRESS: `ledEspera` = 1. On `pressEdge`, load `dadoCapturado` with the synchronized switches and go to ESPERA_SOLTAR.
  - ESPERA_SOLTAR: `ledEspera` = 1. On `releaseEdge`, pulse `botaoIN`, set `dadoValido`, and go to ENTREGUE.
  - ENTREGUE: hold `dadoValido` = 1. When `pedidoIN` = 0, clear `dadoValido` and go to OCIOSO.
- Abort: if `pedidoIN` falls in ESPERA_PRESS or ESPERA_SOLTAR, return to OCIOSO. No `botaoIN` pulse is issued and `dadoCapturado` keeps its previous value.
- Only edges occurring in ESPERA_PRESS count. If the key is already held when a request arrives, the operator must release it and press again.
- Presses in OCIOSO or ENTREGUE are ignored.
- `dadoCapturado` changes only on capture or reset.

## Timing
- Reset values: `dadoCapturado` = 0, `dadoValido` = 0, `botaoIN` = 0, `ledEspera` = 0; FSM in OCIOSO; debounced key = released; synchronizers = released/0; counter = 0.
- Raw key edge to `pressEdge`/`releaseEdge`: `SYNC_STAGES` + `DEBOUNCE_CYCLES` cycles for a clean edge. Any bounce restarts the count.
- `pedidoIN` rise to `ledEspera` = 1: 1 cycle (registered).
- `releaseEdge` to `botaoIN` and `dadoValido`: 1 cycle. `botaoIN` lasts exactly 1 cycle.
- `pedidoIN` fall in ENTREGUE to `dadoValido` = 0: 1 cycle.
- Simultaneous events:
  - `pedidoIN` fall and `pressEdge`/`releaseEdge` in the same cycle: the abort wins.
  - `pedidoIN` rise and `pressEdge` in the same cycle while in OCIOSO: the press is ignored.
- Reset asserted mid-operation: all state returns to reset values immediately. No pulse is generated on reset deassertion.

## Structure
- Shared package holds:
  - FSM state encoding localparams (OCIOSO = 2'd0, ESPERA_PRESS = 2'd1, ESPERA_SOLTAR = 2'd2, ENTREGUE = 2'd3).
  - The `DEBOUNCE_CYCLES` default.
  - The `ledin` LED index constant, shared with the control unit.
- One sub-module, `filtro_debounce` (synchronizer + counter + edge strobes), parameterized by `DEBOUNCE_CYCLES` and `SYNC_STAGES`, is instantiated once for the key.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `SYNC_STAGES` = 2.
- Reset: hold `reset` = 0 with key pressed and switches = 4'hF → all outputs 0. After release with no request → outputs remain 0.
- Normal IN: `pedidoIN` = 1, switches = 4'hA, clean press for 10 cycles then release →
  - `ledEspera` = 1 until release;
  - one `botaoIN` pulse;
  - `dadoCapturado` = 32'h0000000A with `dadoValido` = 1 until `pedidoIN` = 0, then `dadoValido` = 0 the next cycle.
- Bounce: key toggling every 2 cycles for 20 cycles, then stable pressed → exactly one `pressEdge`, `SYNC_STAGES` + 4 cycles after the last toggle. Value captured once.
- Held key: key pressed before `pedidoIN` rises → no capture. After release and a new press/release with switches = 4'h3 → `dadoCapturado` = 32'h3, single `botaoIN`.
- Abort: `pedidoIN` drops in ESPERA_SOLTAR → no `botaoIN`, `dadoValido` stays 0, FSM in OCIOSO, `dadoCapturado` unchanged.
- Reset mid-request: `reset` = 0 in ESPERA_SOLTAR → immediate return to reset values. After deassertion with `pedidoIN` = 0 → no `botaoIN` pulse.

Source files
------------

// File: rtl/captura_entrada_pkg.sv
// -----------------------------------------------------------------------------
// captura_entrada_pkg
// Shared definitions for the IN-path capture stage and the control unit:
//   - FSM state encoding (raw codes plus an enum built on them)
//   - default debounce/synchronizer depths
//   - datum widths and the LED index that shows "waiting for operator"
// -----------------------------------------------------------------------------
package captura_entrada_pkg;

  // Raw state codes; the control unit decodes these directly.
  localparam logic [1:0] ENC_OCIOSO        = 2'd0;
  localparam logic [1:0] ENC_ESPERA_PRESS  = 2'd1;
  localparam logic [1:0] ENC_ESPERA_SOLTAR = 2'd2;
  localparam logic [1:0] ENC_ENTREGUE      = 2'd3;

  typedef enum logic [1:0] {
    OCIOSO        = ENC_OCIOSO,
    ESPERA_PRESS  = ENC_ESPERA_PRESS,
    ESPERA_SOLTAR = ENC_ESPERA_SOLTAR,
    ENTREGUE      = ENC_ENTREGUE
  } estado_t;

  // 10 ms at 50 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned SYNC_STAGES_DEF     = 2;

  localparam int unsigned SW_W   = 4;
  localparam int unsigned DADO_W = 32;

  // Board LED that lights while an IN instruction waits for the operator.
  localparam int unsigned LEDIN_IDX = 0;

endpackage

// File: rtl/captura_entrada_filtro.sv
// -----------------------------------------------------------------------------
// filtro_debounce
// Synchronizes an asynchronous active-low key and debounces it. A level change
// is accepted only after the synchronized key has disagreed with the debounced
// state for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
// Ports:
//   clock, reset      : system clock, asynchronous active-low reset
//   botao_n_i         : raw key, active-low (0 = pressed)
//   press_edge_o      : 1-cycle strobe, debounced key became pressed
//   release_edge_o    : 1-cycle strobe, debounced key became released
// -----------------------------------------------------------------------------
module filtro_debounce
  import captura_entrada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_n_i,
  output logic press_edge_o,
  output logic release_edge_o
);

  localparam int unsigned         CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   deb_q, deb_d;   // 1 = released
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], botao_n_i};
    deb_d     = deb_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync_q[SYNC_STAGES-1] != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d     = ~deb_q;
        press_d   = deb_q;    // released -> pressed
        release_d = ~deb_q;   // pressed -> released
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q    <= '1;        // synchronizer starts at "released"
      deb_q     <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign press_edge_o   = press_q;
  assign release_edge_o = release_q;

endmodule

// File: rtl/captura_entrada.sv
// -----------------------------------------------------------------------------
// captura_entrada
// Input-capture stage upstream of the CPU IN path. Serves one IN request at a
// time: waits for a debounced press, latches the synchronized switches, and on
// the matching release raises dadoValido and a single botaoIN pulse.
// Ports:
//   clock, reset    : system clock, asynchronous active-low reset
//   botaoPlaca      : raw board key, active-low
//   entradaDeDados  : raw 4-bit switches
//   pedidoIN        : level request from the control unit
//   dadoCapturado   : captured switches, zero-extended to 32 bits
//   dadoValido      : datum valid for the current request
//   botaoIN         : 1-cycle completion pulse
//   ledEspera       : waiting-for-operator indicator
// -----------------------------------------------------------------------------
module captura_entrada
  import captura_entrada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              botaoPlaca,
  input  logic [SW_W-1:0]   entradaDeDados,
  input  logic              pedidoIN,
  output logic [DADO_W-1:0] dadoCapturado,
  output logic              dadoValido,
  output logic              botaoIN,
  output logic              ledEspera
);

  logic press_edge;
  logic release_edge;

  filtro_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_filtro (
    .clock          (clock),
    .reset          (reset),
    .botao_n_i      (botaoPlaca),
    .press_edge_o   (press_edge),
    .release_edge_o (release_edge)
  );

  // Switches are synchronized bit by bit only: they are stable long before a
  // debounced press can occur, so no multi-bit coherence logic is needed.
  logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync_q, sw_sync_d;

  estado_t         estado_q, estado_d;
  logic [SW_W-1:0] dado_q, dado_d;
  logic            valido_q, valido_d;
  logic            botao_in_q, botao_in_d;
  logic            led_q, led_d;

  always_comb begin
    sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], entradaDeDados};
    estado_d  = estado_q;
    dado_d    = dado_q;
    // A falling pedidoIN is tested first in every waiting state so an abort
    // wins over a simultaneous edge strobe. Edges seen in OCIOSO are dropped.
    case (estado_q)
      OCIOSO: begin
        if (pedidoIN) estado_d = ESPERA_PRESS;
      end
      ESPERA_PRESS: begin
        if (!pedidoIN) begin
          estado_d = OCIOSO;
        end else if (press_edge) begin
          estado_d = ESPERA_SOLTAR;
          dado_d   = sw_sync_q[SYNC_STAGES-1];
        end
      end
      ESPERA_SOLTAR: begin
        if (!pedidoIN)         estado_d = OCIOSO;
        else if (release_edge) estado_d = ENTREGUE;
      end
      ENTREGUE: begin
        if (!pedidoIN) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    // Outputs are decoded from the next state and registered with it.
    led_d      = (estado_d == ESPERA_PRESS) || (estado_d == ESPERA_SOLTAR);
    valido_d   = (estado_d == ENTREGUE);
    botao_in_d = (estado_q == ESPERA_SOLTAR) && (estado_d == ENTREGUE);
  end

  // NOTE: every flop here is plain control/data state with a defined reset
  // value; there is no memory array that would be left unreset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_sync_q  <= '0;
      estado_q   <= OCIOSO;
      dado_q     <= '0;
      valido_q   <= 1'b0;
      botao_in_q <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      sw_sync_q  <= sw_sync_d;
      estado_q   <= estado_d;
      dado_q     <= dado_d;
      valido_q   <= valido_d;
      botao_in_q <= botao_in_d;
      led_q      <= led_d;
    end
  end

  assign dadoCapturado = {{(DADO_W - SW_W){1'b0}}, dado_q};
  assign dadoValido    = valido_q;
  assign botaoIN       = botao_in_q;
  assign ledEspera     = led_q;

endmodule
